// File: rtl/bus_arbiter_nxm.sv
// Shared-bus interconnect: round-robin arbitration of NUM_M masters onto NUM_S address-windowed slaves.
// Optional grant-hold timeout is built only when the BUS_TIMEOUT_EN macro is defined.
//
//   state | meaning
//   IDLE  | no grant; pick next requester in round-robin order from rr_q
//   GRANT | one master owns the bus until it drops its request (or the hold times out)
module bus_arbiter_nxm #(
   parameter int NUM_M   = 2,
   parameter int NUM_S   = 4,
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int SLV_AW  = 5,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_M-1:0]    M_req,
   input  logic [NUM_M-1:0]    M_wr,
   input  logic [NUM_M*AW-1:0] M_addr,
   input  logic [NUM_M*DW-1:0] M_dout,
   output logic [NUM_M-1:0]    M_grant,
   output logic [DW-1:0]       M_din,
   output logic [NUM_S-1:0]    S_sel,
   output logic [AW-1:0]       S_addr,
   output logic [DW-1:0]       S_din,
   output logic                S_wr,
   input  logic [NUM_S*DW-1:0] S_dout
);

   localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SW = AW - SLV_AW;

   if (NUM_M < 1 || NUM_M > 8 || NUM_S < 1 || NUM_S > (1 << SW) || TIMEOUT < 1) begin : g_param_check
      $error("bus_arbiter_nxm: illegal parameter combination");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [NUM_M-1:0] grant_q, grant_d;
   logic [NUM_M-1:0] eligible;
   logic [MW-1:0]    g_q, g_d, rr_q, rr_d, pick;
   logic             found, req_g, hold_expired;
   logic [AW-1:0]    fwd_addr;
   logic [DW-1:0]    fwd_dout;
   logic             fwd_wr;
   logic [SW-1:0]    idx, rd_idx_q;
   logic             valid, rd_v_q;

`ifdef BUS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    cnt_q;
   logic [NUM_M-1:0] blocked_q, blocked_d;

   // Down-counter reloads throughout IDLE, so every new grant starts a fresh hold window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            cnt_q <= CW'(TIMEOUT - 1);
      else if (state_q == IDLE) cnt_q <= CW'(TIMEOUT - 1);
      else                     cnt_q <= cnt_q - 1'b1;
   end

   assign hold_expired = (state_q == GRANT) && (cnt_q == '0);

   // A revoked master stays ineligible until it is seen with its request low while idle.
   always_comb begin
      blocked_d = blocked_q;
      if (state_q == IDLE)   blocked_d = blocked_q & M_req;
      else if (hold_expired) blocked_d = blocked_q | grant_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) blocked_q <= '0;
      else          blocked_q <= blocked_d;
   end

   assign eligible = M_req & ~blocked_q;
`else
   assign hold_expired = 1'b0;
   assign eligible     = M_req;
`endif

   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (!found && eligible[(int'(rr_q) + i) % NUM_M]) begin
            found = 1'b1;
            pick  = MW'((int'(rr_q) + i) % NUM_M);
         end
      end
   end

   assign req_g = |(M_req & grant_q);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      g_d     = g_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = NUM_M'(1) << pick;
               g_d     = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!req_g || hold_expired) begin
               grant_d = '0;
               rr_d    = MW'((int'(g_q) + 1) % NUM_M);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         g_q     <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
      end
   end

   // Grant is one-hot, so a plain select yields zeros on every forwarded field when idle.
   always_comb begin
      fwd_addr = '0;
      fwd_dout = '0;
      fwd_wr   = 1'b0;
      for (int k = 0; k < NUM_M; k++) begin
         if (grant_q[k]) begin
            fwd_addr = M_addr[k*AW +: AW];
            fwd_dout = M_dout[k*DW +: DW];
            fwd_wr   = M_wr[k];
         end
      end
   end

   assign idx   = fwd_addr[AW-1:SLV_AW];
   assign valid = (|grant_q) && (int'(idx) < NUM_S);

   always_comb begin
      S_sel = '0;
      for (int i = 0; i < NUM_S; i++) S_sel[i] = valid && (int'(idx) == i);
   end

   assign S_addr  = fwd_addr;
   assign S_din   = fwd_dout;
   assign S_wr    = fwd_wr & valid;
   assign M_grant = grant_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_idx_q <= '0;
         rd_v_q   <= 1'b0;
      end else begin
         rd_idx_q <= idx;
         rd_v_q   <= valid & ~fwd_wr;
      end
   end

   always_comb begin
      M_din = '0;
      for (int i = 0; i < NUM_S; i++) begin
         if (rd_v_q && (int'(rd_idx_q) == i)) M_din = S_dout[i*DW +: DW];
      end
   end

endmodule

// File: tb/tb_bus_arbiter_nxm.sv
// Directed bench for bus_arbiter_nxm (NUM_M=2, NUM_S=4, AW=8, SLV_AW=5, TIMEOUT=8).
// Table vectors cover decode/forwarding/read return; hand sequences cover reset, round-robin and hold.
module tb_bus_arbiter_nxm;

   localparam int NUM_M = 2, NUM_S = 4, AW = 8, DW = 32, SLV_AW = 5, TIMEOUT = 8;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NUM_M-1:0]    M_req, M_wr, M_grant;
   logic [NUM_M*AW-1:0] M_addr;
   logic [NUM_M*DW-1:0] M_dout;
   logic [DW-1:0]       M_din, S_din;
   logic [NUM_S-1:0]    S_sel;
   logic [AW-1:0]       S_addr;
   logic                S_wr;
   logic [NUM_S*DW-1:0] S_dout;

   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] dout0, dout1;
   logic [DW-1:0] slv [NUM_S];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign M_addr = {addr1, addr0};
   assign M_dout = {dout1, dout0};
   assign S_dout = {slv[3], slv[2], slv[1], slv[0]};

   bus_arbiter_nxm #(
      .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .SLV_AW(SLV_AW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .M_req(M_req), .M_wr(M_wr), .M_addr(M_addr), .M_dout(M_dout),
      .M_grant(M_grant), .M_din(M_din),
      .S_sel(S_sel), .S_addr(S_addr), .S_din(S_din), .S_wr(S_wr),
      .S_dout(S_dout)
   );

   typedef struct {
      logic [1:0]  req;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] dout;
      logic [31:0] slv1;
      logic [3:0]  sel;
      logic        swr;
      logic [31:0] din;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drop M0's request for one cycle then re-request so the hold never nears TIMEOUT.
   task automatic regrant();
      M_req = 2'b00; M_wr = 2'b00;
      tick();
      M_req = 2'b01;
      tick();
      chk("regrant", 32'(M_grant), 32'h1);
   endtask

   initial begin
      logic [1:0] exp_g;

      vecs[0]  = '{2'b01, 1'b1, 8'h25, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0010, 1'b1, 32'h0};
      vecs[1]  = '{2'b01, 1'b0, 8'h25, 32'h0,        32'hDEADBEEF, 4'b0010, 1'b0, 32'hDEADBEEF};
      vecs[2]  = '{2'b11, 1'b1, 8'h9C, 32'h12345678, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h0};
      vecs[3]  = '{2'b11, 1'b0, 8'h25, 32'h0,        32'hDEADBEEF, 4'b0010, 1'b0, 32'hDEADBEEF};
      vecs[4]  = '{2'b11, 1'b0, 8'h9C, 32'h0,        32'hDEADBEEF, 4'b0000, 1'b0, 32'h0};
      vecs[5]  = '{2'b01, 1'b0, 8'h00, 32'h0,        32'h101,      4'b0001, 1'b0, 32'h100};
      vecs[6]  = '{2'b01, 1'b0, 8'h20, 32'h0,        32'h101,      4'b0010, 1'b0, 32'h101};
      vecs[7]  = '{2'b01, 1'b0, 8'h40, 32'h0,        32'h101,      4'b0100, 1'b0, 32'h102};
      vecs[8]  = '{2'b01, 1'b0, 8'h60, 32'h0,        32'h101,      4'b1000, 1'b0, 32'h103};
      vecs[9]  = '{2'b01, 1'b0, 8'h7F, 32'h0,        32'h101,      4'b1000, 1'b0, 32'h103};
      vecs[10] = '{2'b01, 1'b0, 8'hE0, 32'h0,        32'h101,      4'b0000, 1'b0, 32'h0};
      vecs[11] = '{2'b01, 1'b1, 8'h1F, 32'hA5A5A5A5, 32'h101,      4'b0001, 1'b1, 32'h0};
      vecs[12] = '{2'b11, 1'b1, 8'hFF, 32'h0,        32'h101,      4'b0000, 1'b0, 32'h0};

      reset_n = 1'b0;
      M_req = 2'b11; M_wr = 2'b00;
      addr0 = 8'h25; addr1 = 8'h40; dout0 = 32'h0; dout1 = 32'h77777777;
      slv[0] = 32'h100; slv[1] = 32'h101; slv[2] = 32'h102; slv[3] = 32'h103;

      repeat (2) tick();
      chk("reset_grant", 32'(M_grant), 32'h0);
      chk("reset_sel",   32'(S_sel),   32'h0);
      chk("reset_din",   M_din,        32'h0);
      chk("reset_saddr", 32'(S_addr),  32'h0);
      chk("reset_swr",   32'(S_wr),    32'h0);
      reset_n = 1'b1;
      tick();
      chk("first_grant", 32'(M_grant), 32'h1);

      for (int i = 0; i < 13; i++) begin
         M_req = vecs[i].req;
         M_wr  = {1'b0, vecs[i].wr};
         addr0 = vecs[i].addr;
         dout0 = vecs[i].dout;
         slv[1] = vecs[i].slv1;
         #1;
         chk($sformatf("v%0d_grant", i), 32'(M_grant), 32'h1);
         chk($sformatf("v%0d_sel", i),   32'(S_sel),   32'(vecs[i].sel));
         chk($sformatf("v%0d_swr", i),   32'(S_wr),    32'(vecs[i].swr));
         chk($sformatf("v%0d_saddr", i), 32'(S_addr),  32'(vecs[i].addr));
         chk($sformatf("v%0d_sdin", i),  S_din,        vecs[i].dout);
         tick();
         chk($sformatf("v%0d_mdin", i),  M_din,        vecs[i].din);
         if (i == 4 || i == 9) regrant();
      end

      // M0 drops its request in the same cycle as a read of slave 2.
      M_req = 2'b10; M_wr = 2'b00; addr0 = 8'h40;
      #1;
      chk("drop_sel", 32'(S_sel), 32'h4);
      tick();
      chk("drop_idle_grant", 32'(M_grant), 32'h0);
      chk("drop_last_rd",    M_din,        32'h102);
      chk("drop_idle_sel",   32'(S_sel),   32'h0);

      // Both request during IDLE; rr pointer now favours M1.
      M_req = 2'b11;
      tick();
      chk("rr_m1_grant", 32'(M_grant), 32'h2);
      addr1 = 8'h60;
      #1;
      chk("m1_sel",   32'(S_sel),  32'h8);
      chk("m1_saddr", 32'(S_addr), 32'h60);
      tick();
      chk("m1_rd", M_din, 32'h103);

      M_req = 2'b01;
      tick();
      chk("m1_drop_idle", 32'(M_grant), 32'h0);
      tick();
      chk("rr_m0_grant", 32'(M_grant), 32'h1);

      // Long hold by M0 while M1 waits.
      M_req = 2'b11; addr0 = 8'h00;
      for (int i = 1; i <= 12; i++) begin
         tick();
`ifdef BUS_TIMEOUT_EN
         exp_g = (i < 8) ? 2'b01 : ((i == 8) ? 2'b00 : 2'b10);
`else
         exp_g = 2'b01;
`endif
         chk($sformatf("hold_%0d", i), 32'(M_grant), 32'(exp_g));
      end

      // Asynchronous reset in the middle of a grant.
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_grant", 32'(M_grant), 32'h0);
      chk("midrst_sel",   32'(S_sel),   32'h0);
      chk("midrst_din",   M_din,        32'h0);
      M_req = 2'b00;
      #1;
      reset_n = 1'b1;
      tick();
      chk("post_rst_idle", 32'(M_grant), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
